// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the core's data-memory request interface, backed by a
//   word-organised on-chip array. One request is captured in IDLE, held for
//   WAIT_STATES cycles, then answered with a one-cycle mem_ready pulse.
//   Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) are answered with
//   mem_error instead of touching the array.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   mem_valid   request strobe (sampled in IDLE only)
//   mem_instr   fetch qualifier, captured but behaviourally inert
//   mem_addr    byte address
//   mem_wdata   lane-aligned store data
//   mem_wstrb   byte write enables, 0 = read
//   mem_ready   one-cycle response strobe
//   mem_rdata   read data, zero unless mem_ready on an in-range read
//   mem_error   out-of-range flag, only with mem_ready
module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  WS4       = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_instr_unused;
  logic          r_in_range;
  logic          r_rd_ok;
  logic [31:0]   r_rd_word;
  logic [31:0]   r_mem [DEPTH];

  logic          w_in_range;
  logic [AW-1:0] w_cap_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_capture;
  logic          w_re;
  logic          w_we;

  always_comb begin
    w_in_range = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < LIMIT);
    w_cap_idx  = AW'((mem_addr - BASE_ADDR) >> 2);
    w_capture  = (r_state == S_IDLE) && mem_valid;
    // The array is read one edge before RESP: in the final WAIT cycle, or
    // straight from the live request when there are no wait states.
    w_rd_idx   = ZERO_WAIT ? w_cap_idx : r_idx;
    w_re       = ZERO_WAIT ? w_capture : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    // Write commits on the edge that ends RESP; a reset on that edge aborts it.
    w_we       = (r_state == S_RESP) && r_in_range && (r_wstrb != 4'h0) && !rst;
  end

  // Storage kept free of reset so a synchronous SRAM can be inferred.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
    if (w_re) r_rd_word <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      mem_ready      <= 1'b0;
      r_idx          <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_instr_unused <= 1'b0;
      r_in_range     <= 1'b0;
      r_rd_ok        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          mem_ready <= 1'b0;
          if (mem_valid) begin
            r_idx          <= w_cap_idx;
            r_wdata        <= mem_wdata;
            r_wstrb        <= mem_wstrb;
            r_instr_unused <= mem_instr;
            r_in_range     <= w_in_range;
            r_rd_ok        <= w_in_range && (mem_wstrb == 4'h0);
            r_cnt          <= WS4;
            if (ZERO_WAIT) begin
              r_state   <= S_RESP;
              mem_ready <= 1'b1;
            end else begin
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= S_RESP;
            mem_ready <= 1'b1;
          end
        end
        S_RESP: begin
          mem_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_rdata = (mem_ready && r_rd_ok) ? r_rd_word : '0;
    mem_error = mem_ready && !r_in_range;
  end

  a_valid_known: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_IDLE) |-> !$isunknown(mem_valid));
  a_ready_pulse: assert property (@(posedge clk) disable iff (rst)
    mem_ready |=> !mem_ready);
  a_err_ready:   assert property (@(posedge clk) disable iff (rst)
    mem_error |-> mem_ready);
  a_rdata_zero:  assert property (@(posedge clk) disable iff (rst)
    !mem_ready |-> (mem_rdata == '0));

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Four responders (DEPTH=16) with different wait-state counts and bases.
//   Stimulus pushes the expected response (due cycle, rdata, error) into a
//   per-instance queue; an independent negedge monitor pops and compares.
//   inst 0: WAIT_STATES=1, base 0
//   inst 1: WAIT_STATES=0, base 0x8000_0000
//   inst 2: WAIT_STATES=3, base 0
//   inst 3: WAIT_STATES=2, base 0
module tb_dmem_responder;

  localparam logic [15:0] WS_PACK = {4'd2, 4'd3, 4'd0, 4'd1};

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst   [4];
  logic        valid [4];
  logic        instr [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  wstrb [4];
  logic        ready [4];
  logic [31:0] rdata [4];
  logic        err   [4];

  exp_t exp_q [4][$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   mon_en = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH      (16),
      .BASE_ADDR  ((g == 1) ? 32'h8000_0000 : 32'h0000_0000),
      .WAIT_STATES(int'(WS_PACK[4*g +: 4]))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .mem_valid(valid[g]),
      .mem_instr(instr[g]),
      .mem_addr (addr[g]),
      .mem_wdata(wdata[g]),
      .mem_wstrb(wstrb[g]),
      .mem_ready(ready[g]),
      .mem_rdata(rdata[g]),
      .mem_error(err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int g);
    logic [15:0] p;
    p = WS_PACK;
    return int'(p[4*g +: 4]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int g, input int due, input logic [31:0] rd, input logic e);
    exp_t x;
    x.due   = due;
    x.rdata = rd;
    x.err   = e;
    exp_q[g].push_back(x);
  endtask

  // Called at a negedge with the instance idle; returns at the first negedge
  // on which the instance can accept a new request.
  task automatic req(input int g, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee);
    valid[g] = 1'b1;
    instr[g] = a[2];
    addr[g]  = a;
    wdata[g] = d;
    wstrb[g] = s;
    push_exp(g, cyc + 1 + ws_of(g), er, ee);
    @(negedge clk);
    valid[g] = 1'b0;
    wstrb[g] = 4'h0;
    repeat (ws_of(g) + 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 4; g++) begin
        if (ready[g] === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            chk($sformatf("unexpected_ready[%0d]", g), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[g].pop_front();
            chk($sformatf("latency[%0d]", g), cyc, mon_e.due);
            chk($sformatf("rdata[%0d]", g), rdata[g], mon_e.rdata);
            chk($sformatf("error[%0d]", g), {31'd0, err[g]}, {31'd0, mon_e.err});
          end
        end else begin
          chk($sformatf("idle_rdata[%0d]", g), rdata[g], 32'd0);
          chk($sformatf("idle_error[%0d]", g), {31'd0, err[g]}, 32'd0);
          if (exp_q[g].size() != 0 && exp_q[g][0].due < cyc) begin
            chk($sformatf("missing_ready[%0d]", g), cyc, exp_q[g][0].due);
            void'(exp_q[g].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int g = 0; g < 4; g++) begin
      rst[g] = 1'b1; valid[g] = 1'b0; instr[g] = 1'b0;
      addr[g] = '0; wdata[g] = '0; wstrb[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_ready[%0d]", g), {31'd0, ready[g]}, 32'd0);
      chk($sformatf("reset_rdata[%0d]", g), rdata[g], 32'd0);
      chk($sformatf("reset_error[%0d]", g), {31'd0, err[g]}, 32'd0);
      rst[g] = 1'b0;
    end
    mon_en = 1'b1;
    @(negedge clk);

    // inst 0: full store, load, byte merge, ignored low address bits
    req(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    req(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    req(0, 32'h12, 32'h00AA0000, 4'h4, 32'h0,        1'b0);
    req(0, 32'h10, 32'h0,        4'h0, 32'hDEAABEEF, 1'b0);
    req(0, 32'h13, 32'h0,        4'h0, 32'hDEAABEEF, 1'b0);
    // inst 0: one-past-end load/store leave words 0 and DEPTH-1 intact
    req(0, 32'h00, 32'h01234567, 4'hF, 32'h0,        1'b0);
    req(0, 32'h3C, 32'h89ABCDEF, 4'hF, 32'h0,        1'b0);
    req(0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1);
    req(0, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
    req(0, 32'h00, 32'h0,        4'h0, 32'h01234567, 1'b0);
    req(0, 32'h3C, 32'h0,        4'h0, 32'h89ABCDEF, 1'b0);
    req(0, 32'h3D, 32'h00005500, 4'h2, 32'h0,        1'b0);
    req(0, 32'h3C, 32'h0,        4'h0, 32'h89AB55EF, 1'b0);

    // inst 1: zero wait states, non-zero base, valid ignored during RESP
    req(1, 32'h8000_0008, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    c = cyc;
    valid[1] = 1'b1; addr[1] = 32'h8000_0008; wstrb[1] = 4'h0;
    push_exp(1, c + 1, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    addr[1] = 32'h8000_0008; wdata[1] = 32'h0; wstrb[1] = 4'hF;
    @(negedge clk);
    addr[1] = 32'h8000_0008; wstrb[1] = 4'h0;
    push_exp(1, c + 3, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    valid[1] = 1'b0;
    @(negedge clk);
    req(1, 32'h7FFF_FFFC, 32'h0,        4'h0, 32'h0,        1'b1);
    req(1, 32'h8000_0040, 32'h0,        4'h0, 32'h0,        1'b1);
    req(1, 32'h8000_003C, 32'h13572468, 4'hF, 32'h0,        1'b0);
    req(1, 32'h8000_003C, 32'h0,        4'h0, 32'h13572468, 1'b0);

    // inst 2: reset in WAIT aborts a store with no ready pulse
    req(2, 32'h20, 32'h11112222, 4'hF, 32'h0,        1'b0);
    req(2, 32'h20, 32'h0,        4'h0, 32'h11112222, 1'b0);
    valid[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h99999999; wstrb[2] = 4'hF;
    @(negedge clk);
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready[2]}, 32'd0);
    chk("abort_rdata", rdata[2], 32'd0);
    chk("abort_error", {31'd0, err[2]}, 32'd0);
    rst[2] = 1'b0;
    repeat (5) @(negedge clk);
    req(2, 32'h20, 32'h0, 4'h0, 32'h11112222, 1'b0);

    // inst 3: preload, then mem_valid held high for ten transactions
    for (int i = 0; i < 16; i++) req(3, 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0, 1'b0);
    c = cyc;
    for (int k = 0; k < 40; k++) begin
      valid[3] = 1'b1;
      addr[3]  = 32'(4 * (k % 16));
      wstrb[3] = 4'h0;
      if (k % 4 == 0) push_exp(3, c + k + 3, 32'hC0DE0000 + 32'(k % 16), 1'b0);
      @(negedge clk);
    end
    valid[3] = 1'b0;

    repeat (8) @(negedge clk);
    for (int g = 0; g < 4; g++) chk($sformatf("queue_empty[%0d]", g), 32'(exp_q[g].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data-memory request interface (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb in; mem_ready/mem_rdata out).
- Sits between the pipeline's data-memory request port and an on-chip word-organised SRAM array held inside this block.
- Captures one request, waits a programmable number of cycles, performs a byte-masked write or a word read, and returns a single-cycle ready pulse with read data.
- Addresses outside its window are answered with an error flag rather than a hang.

Parameters:
- DEPTH, 4096, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- WAIT_STATES, 1, extra cycles between capture and response; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  request strobe
- mem_instr  in  1  instruction-fetch qualifier; carried only, no behavioural effect
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, already lane-aligned by the requester
- mem_wstrb  in  4  byte write enables; 0 means read
- mem_ready  out  1  one-cycle response strobe
- mem_rdata  out  32  read data, valid only while mem_ready=1
- mem_error  out  1  asserted with mem_ready when the captured address was out of range

Behaviour:
- Reset value: mem_ready=0, mem_rdata=0, mem_error=0. FSM goes to IDLE and the wait counter is 0. Array contents are not reset.
- Reset asserted mid-transaction aborts it: no write occurs unless the write cycle was already committed in an earlier clock, and no ready pulse is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_valid=1, register addr, wdata, wstrb, instr.
  - Compute in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH).
  - Load cnt = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: cnt decrements each cycle; at cnt==1 go to RESP. WAIT lasts exactly WAIT_STATES cycles.
- RESP:
  - mem_ready=1 for exactly this cycle; next state IDLE.
  - Word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]. addr[1:0] is ignored for indexing.
  - In range, wstrb != 0: on this clock edge, write byte lane i from wdata[8i+7:8i] for each wstrb[i]=1. Other lanes are unchanged. mem_rdata = 0.
  - In range, wstrb == 0: mem_rdata = the full stored word. The requester extracts sub-words.
  - Out of range: no write; mem_rdata = 0; mem_error = 1.
- Latency: request accepted at edge N; mem_ready high in cycle N+1+WAIT_STATES. With WAIT_STATES=0 this is a single-cycle response.
- Back-to-back: mem_valid is ignored while in WAIT or RESP; the requester must hold off until it sees mem_ready. The next request can be sampled in the cycle after RESP (IDLE). Throughput is one request per WAIT_STATES+2 cycles.
- Read data comes from a registered array read, so a synchronous SRAM is inferable. The array read address is presented in the final WAIT cycle, or in the capture cycle when WAIT_STATES=0.
- Read-after-write to the same word in consecutive transactions returns the newly written data.
- mem_valid must be driven 0 or 1; an X on mem_valid in IDLE is a bench error and is flagged by an assertion.
- Assertions:
  - mem_ready is never high two cycles in a row.
  - mem_error implies mem_ready.
  - mem_rdata == 0 whenever mem_ready == 0.

Test Plan:
- WAIT_STATES=1, store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then load addr=0x10 -> ready 2 cycles after each capture; load returns 0xDEADBEEF, error=0.
- Byte store addr=0x12, wdata=0x00AA0000, wstrb=4'b0100 over 0xDEADBEEF, then load 0x10 -> 0xDEAAEEF... checked per lane: result 0xDEAABEEF.
- WAIT_STATES=0, load issued in cycle 0 -> mem_ready=1 in cycle 1; a new mem_valid in cycle 1 is ignored; one sampled in cycle 2 responds in cycle 3.
- Load addr=BASE_ADDR+4*DEPTH (one past end) -> mem_ready=1, mem_error=1, rdata=0. Store to the same address changes no word; verified by a sweep readback of words 0 and DEPTH-1.
- rst asserted in WAIT during a store to 0x20 (WAIT_STATES=3) -> no ready pulse; outputs 0 the next cycle; load 0x20 afterward returns the prior value.
- mem_valid held high continuously for 10 transactions (WAIT_STATES=2) -> exactly one ready per 4 cycles, addresses taken at each IDLE sample.
